// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage pipe: tracks ex/mem/wb producers, interlocks ID, drives EX forwarding selects.
// Build option FORWARD_EN: defined = forwarding with load-use-only stalls; undefined = selects tied to 00, interlock on any ex/mem producer.
module hazard_scoreboard #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_valid_i,
    input  logic [4:0]             id_rs1_i,
    input  logic [4:0]             id_rs2_i,
    input  logic [4:0]             id_rd_i,
    input  logic                   id_use_rs1_i,
    input  logic                   id_use_rs2_i,
    input  logic                   id_RegWrite_i,
    input  logic                   id_MemRead_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic                   bubble_o,
    output logic [1:0]             ForwardA_o,
    output logic [1:0]             ForwardB_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } src_t;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    slot_t                  ex_q, ex_d;
    slot_t                  mem_q, mem_d;
    slot_t                  wb_q, wb_d;
    src_t                   ex_src_q, ex_src_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit;
    logic raw_hazard;
    logic stall;
    logic issue;

    function automatic logic slot_match(slot_t s, logic [4:0] r);
        return s.valid & s.reg_write & (s.rd != 5'd0) & (s.rd == r);
    endfunction

    assign ex_hit = (id_use_rs1_i & slot_match(ex_q, id_rs1_i)) |
                    (id_use_rs2_i & slot_match(ex_q, id_rs2_i));

`ifdef FORWARD_EN
    // Only a load in EX cannot be forwarded in time; everything else bypasses.
    assign raw_hazard = ex_hit & ex_q.mem_read;

    function automatic logic [1:0] fwd_sel(slot_t ex, slot_t mem, slot_t wb,
                                           logic [4:0] r, logic use_r);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex.valid && use_r) begin
            if (slot_match(mem, r)) begin
                sel = 2'b10;
            end else if (slot_match(wb, r)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign ForwardA_o = fwd_sel(ex_q, mem_q, wb_q, ex_src_q.rs1, ex_src_q.use_rs1);
    assign ForwardB_o = fwd_sel(ex_q, mem_q, wb_q, ex_src_q.rs2, ex_src_q.use_rs2);

    logic unused_fwd;
    assign unused_fwd = mem_q.mem_read ^ wb_q.mem_read;
`else
    logic mem_hit;

    // No bypass network: wait until the producer reaches WB (write-first regfile).
    assign mem_hit = (id_use_rs1_i & slot_match(mem_q, id_rs1_i)) |
                     (id_use_rs2_i & slot_match(mem_q, id_rs2_i));
    assign raw_hazard = ex_hit | mem_hit;

    assign ForwardA_o = 2'b00;
    assign ForwardB_o = 2'b00;

    logic unused_nofwd;
    assign unused_nofwd = ^{ex_q.mem_read, ex_src_q, mem_q.mem_read, wb_q};
`endif

    assign stall    = id_valid_i & ~flush_i & raw_hazard;
    assign issue    = id_valid_i & ~stall & ~flush_i;
    assign stall_o  = stall;
    assign bubble_o = ~issue;

    always_comb begin
        wb_d        = mem_q;
        mem_d       = ex_q;
        ex_d        = ex_q;
        ex_src_d    = ex_src_q;
        ex_d.valid  = 1'b0;
        stall_cnt_d = stall_cnt_q;

        if (issue) begin
            ex_d.valid        = 1'b1;
            ex_d.rd           = id_rd_i;
            ex_d.reg_write    = id_RegWrite_i;
            ex_d.mem_read     = id_MemRead_i;
            ex_src_d.rs1      = id_rs1_i;
            ex_src_d.rs2      = id_rs2_i;
            ex_src_d.use_rs1  = id_use_rs1_i;
            ex_src_d.use_rs2  = id_use_rs2_i;
        end

        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_src_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            ex_src_q    <= ex_src_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: instruction-level pipeline model checked every cycle, plus directed literal checks.
module tb_hazard_scoreboard;

    localparam int W = 4;
    localparam int MAXC = (1 << W) - 1;
`ifdef FORWARD_EN
    localparam bit FWD_MODE = 1'b1;
`else
    localparam bit FWD_MODE = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         id_valid_i;
    logic [4:0]   id_rs1_i, id_rs2_i, id_rd_i;
    logic         id_use_rs1_i, id_use_rs2_i, id_RegWrite_i, id_MemRead_i;
    logic         flush_i;
    logic         stall_o, bubble_o;
    logic [1:0]   ForwardA_o, ForwardB_o;
    logic [W-1:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    hazard_scoreboard #(.STALL_CNT_W(W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .id_valid_i   (id_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_rd_i      (id_rd_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .id_RegWrite_i(id_RegWrite_i),
        .id_MemRead_i (id_MemRead_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .bubble_o     (bubble_o),
        .ForwardA_o   (ForwardA_o),
        .ForwardB_o   (ForwardB_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction-level model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit       we;
        bit       ld;
    } ins_t;

    ins_t pipe [3];
    int   m_cnt = 0;

    function automatic bit produces(ins_t i, bit [4:0] r);
        return i.v && i.we && (r != 5'd0) && (i.rd == r);
    endfunction

    // Stages between ID and the youngest in-flight writer of r (0 = none).
    function automatic int prod_dist(bit [4:0] r);
        for (int d = 0; d < 3; d++) begin
            if (produces(pipe[d], r)) return d + 1;
        end
        return 0;
    endfunction

    function automatic bit src_blocks(bit [4:0] r, bit u);
        int d;
        if (!u) return 1'b0;
        d = prod_dist(r);
        if (FWD_MODE) return (d == 1) && pipe[0].ld;
        return (d == 1) || (d == 2);
    endfunction

    function automatic bit m_stall();
        if (!id_valid_i || flush_i) return 1'b0;
        return src_blocks(id_rs1_i, id_use_rs1_i) || src_blocks(id_rs2_i, id_use_rs2_i);
    endfunction

    function automatic bit m_issue();
        return id_valid_i && !m_stall() && !flush_i;
    endfunction

    function automatic bit [1:0] m_fwd(bit [4:0] r, bit u);
        if (!FWD_MODE || !pipe[0].v || !u) return 2'b00;
        if (produces(pipe[1], r)) return 2'b10;
        if (produces(pipe[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic ins_t mk_ins(bit v);
        ins_t i;
        i.v = v; i.rd = id_rd_i; i.rs1 = id_rs1_i; i.rs2 = id_rs2_i;
        i.u1 = id_use_rs1_i; i.u2 = id_use_rs2_i; i.we = id_RegWrite_i; i.ld = id_MemRead_i;
        return i;
    endfunction

    always @(posedge clk_i) begin
        if (!rst_i) begin
            pipe[0] <= mk_ins(1'b0);
            pipe[1] <= mk_ins(1'b0);
            pipe[2] <= mk_ins(1'b0);
            m_cnt   <= 0;
        end else begin
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            pipe[0] <= mk_ins(m_issue());
            m_cnt   <= (m_stall() && m_cnt < MAXC) ? m_cnt + 1 : m_cnt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("model_stall",  32'(stall_o),     32'(m_stall()));
            check("model_bubble", 32'(bubble_o),    32'(!m_issue()));
            check("model_fwdA",   32'(ForwardA_o),  32'(m_fwd(pipe[0].rs1, pipe[0].u1)));
            check("model_fwdB",   32'(ForwardB_o),  32'(m_fwd(pipe[0].rs2, pipe[0].u2)));
            check("model_cnt",    32'(stall_cnt_o), 32'(m_cnt));
        end
    end

    task automatic put(input bit v, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit u1, input bit u2, input bit we, input bit ld, input bit fl);
        id_valid_i = v; id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
        id_use_rs1_i = u1; id_use_rs2_i = u2; id_RegWrite_i = we; id_MemRead_i = ld;
        flush_i = fl;
        @(negedge clk_i);
    endtask

    task automatic rtype(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        put(1, rd, rs1, rs2, 1, 1, 1, 0, 0);
    endtask

    task automatic itype(input bit [4:0] rd, input bit [4:0] rs1);
        put(1, rd, rs1, 5'd0, 1, 0, 1, 0, 0);
    endtask

    task automatic lw(input bit [4:0] rd, input bit [4:0] rs1);
        put(1, rd, rs1, 5'd0, 1, 0, 1, 1, 0);
    endtask

    task automatic idle();
        put(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b0;
        id_valid_i = 0; id_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
        id_use_rs1_i = 0; id_use_rs2_i = 0; id_RegWrite_i = 0; id_MemRead_i = 0; flush_i = 0;
        adv(); adv();
        rst_i  = 1'b1;
        chk_en = 1'b1;

        // reset state
        idle();
        check("rst_bubble_idle", 32'(bubble_o), 1);
        check("rst_cnt", 32'(stall_cnt_o), 0);
        adv();
        lw(5, 1);
        check("rst_stall", 32'(stall_o), 0);
        check("rst_bubble", 32'(bubble_o), 0);
        check("rst_fwdA", 32'(ForwardA_o), 0);
        check("rst_fwdB", 32'(ForwardB_o), 0);
        adv();

        // load-use: lw x5 ; add x6,x5,x1
        rtype(6, 5, 1);
        check("lu_stall", 32'(stall_o), 1);
        check("lu_bubble", 32'(bubble_o), 1);
        adv();
        rtype(6, 5, 1);
        check("lu_stall2", 32'(stall_o), FWD_MODE ? 0 : 1);
        adv();
        rtype(6, 5, 1);
        check("lu_stall3", 32'(stall_o), 0);
        check("lu_fwdA", 32'(ForwardA_o), FWD_MODE ? 1 : 0);
        check("lu_cnt", 32'(stall_cnt_o), FWD_MODE ? 1 : 2);
        adv();
        repeat (3) begin idle(); adv(); end

        // ALU-ALU: add x3,x1,x2 ; sub x4,x3,x3
        rtype(3, 1, 2); adv();
        rtype(4, 3, 3);
        check("alu_stall1", 32'(stall_o), FWD_MODE ? 0 : 1);
        adv();
        rtype(4, 3, 3);
        check("alu_stall2", 32'(stall_o), FWD_MODE ? 0 : 1);
        check("alu_fwdA", 32'(ForwardA_o), FWD_MODE ? 2 : 0);
        check("alu_fwdB", 32'(ForwardB_o), FWD_MODE ? 2 : 0);
        adv();
        rtype(4, 3, 3);
        check("alu_stall3", 32'(stall_o), 0);
        adv();
        idle();
        check("alu_cnt", 32'(stall_cnt_o), FWD_MODE ? 1 : 4);
        adv();
        repeat (2) begin idle(); adv(); end

        // double producer: addi x7 ; addi x7 ; or x8,x7,x0
        itype(7, 0); adv();
        itype(7, 0);
        check("dp_stall_x0", 32'(stall_o), 0);
        adv();
        rtype(8, 7, 0);
        check("dp_stall1", 32'(stall_o), FWD_MODE ? 0 : 1);
        adv();
        rtype(8, 7, 0);
        check("dp_stall2", 32'(stall_o), FWD_MODE ? 0 : 1);
        check("dp_fwdA", 32'(ForwardA_o), FWD_MODE ? 2 : 0);
        check("dp_fwdB", 32'(ForwardB_o), 0);
        adv();
        rtype(8, 7, 0); adv();
        idle();
        check("dp_cnt", 32'(stall_cnt_o), FWD_MODE ? 1 : 6);
        adv();
        idle(); adv();

        // x0 destination: lw x0 ; add x1,x0,x0
        lw(0, 1); adv();
        rtype(1, 0, 0);
        check("x0_stall", 32'(stall_o), 0);
        adv();
        idle();
        check("x0_fwdA", 32'(ForwardA_o), 0);
        check("x0_fwdB", 32'(ForwardB_o), 0);
        adv();
        idle(); adv();

        // flush on a load-use cycle
        lw(5, 1); adv();
        put(1, 6, 5, 1, 1, 1, 1, 0, 1);
        check("fl_stall", 32'(stall_o), 0);
        check("fl_bubble", 32'(bubble_o), 1);
        adv();
        rtype(7, 6, 0);
        check("fl_next_stall", 32'(stall_o), 0);
        check("fl_next_fwdA", 32'(ForwardA_o), 0);
        adv();
        idle(); adv();

        // reset during a stall cycle
        lw(3, 1); adv();
        rtype(4, 3, 1);
        check("rs_stall", 32'(stall_o), 1);
        check("rs_cnt_before", 32'(stall_cnt_o), FWD_MODE ? 1 : 6);
        rst_i = 1'b0;
        adv();
        rst_i = 1'b1;
        rtype(4, 3, 1);
        check("rs_stall_after", 32'(stall_o), 0);
        check("rs_cnt_after", 32'(stall_cnt_o), 0);
        check("rs_bubble_after", 32'(bubble_o), 0);
        adv();
        idle(); adv();

        // counter saturation (4-bit counter)
        for (int it = 0; it < 16; it++) begin
            lw(3, 1); adv();
            repeat (3) begin rtype(4, 3, 1); adv(); end
            idle();
            if (it == 7) check("sat_cnt_mid", 32'(stall_cnt_o), FWD_MODE ? 8 : 15);
            adv();
        end
        idle();
        check("sat_cnt_final", 32'(stall_cnt_o), 15);
        adv();

        // mixed traffic on a small register set, checked by the model only
        rst_i = 1'b0; idle(); adv();
        rst_i = 1'b1;
        for (int k = 0; k < 120; k++) begin
            put(($urandom_range(0, 9) != 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0));
            adv();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
